// File: rtl/gain_sched_pkg.sv
// ============================================================================
// Module : gain_sched_pkg
// Brief  : Shared types and constants for the gain_sched scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gain_sched_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int FRAC_BITS_DEF  = 10;

    localparam logic [DATA_WIDTH_DEF-1:0] GAIN_ONE = DATA_WIDTH_DEF'(1) << FRAC_BITS_DEF;

    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gain_sched_if.sv
// ============================================================================
// Module : gain_sched_if
// Brief  : Config, input-FIFO and output-FIFO signals of the gain scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface gain_sched_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cfg_wr_en;
    logic                  cfg_ch;
    logic [DATA_WIDTH-1:0] cfg_gain;

    logic [DATA_WIDTH-1:0] l_in_dout;
    logic [DATA_WIDTH-1:0] r_in_dout;
    logic                  l_in_empty;
    logic                  r_in_empty;
    logic                  l_in_rd_en;
    logic                  r_in_rd_en;

    logic [DATA_WIDTH-1:0] l_out_din;
    logic [DATA_WIDTH-1:0] r_out_din;
    logic                  l_out_wr_en;
    logic                  r_out_wr_en;
    logic                  l_out_full;
    logic                  r_out_full;

    logic                  busy;

    modport master (
        output cfg_wr_en, cfg_ch, cfg_gain,
        output l_in_dout, r_in_dout, l_in_empty, r_in_empty,
        output l_out_full, r_out_full,
        input  l_in_rd_en, r_in_rd_en,
        input  l_out_din, r_out_din, l_out_wr_en, r_out_wr_en,
        input  busy
    );

    modport slave (
        input  cfg_wr_en, cfg_ch, cfg_gain,
        input  l_in_dout, r_in_dout, l_in_empty, r_in_empty,
        input  l_out_full, r_out_full,
        output l_in_rd_en, r_in_rd_en,
        output l_out_din, r_out_din, l_out_wr_en, r_out_wr_en,
        output busy
    );

endinterface

`default_nettype wire

// File: rtl/gain_sched_rr.sv
// ============================================================================
// Module : gain_sched_rr
// Brief  : Two-way round-robin picker; on a tie the channel not served last wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gain_sched_rr (
    input  logic [1:0] eligible,
    input  logic       last_ch,
    output logic       grant_valid,
    output logic       grant_ch
);

    assign grant_valid = |eligible;
    assign grant_ch    = (&eligible) ? ~last_ch : eligible[1];

endmodule

`default_nettype wire

// File: rtl/gain_sched.sv
// ============================================================================
// Module : gain_sched
// Brief  : Time-multiplexed fixed-point gain for L/R channels (IDLE/MUL/WRITE).
//          Define GAIN_SCHED_SAT_EN to saturate instead of wrap the result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gain_sched
    import gain_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    gain_sched_if.slave bus
);

    localparam logic [DATA_WIDTH-1:0] c_gain_one = DATA_WIDTH'(1) << FRAC_BITS;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic                         r_last_ch;
    logic                         r_cur_ch;
    logic signed [DATA_WIDTH-1:0] r_sample;
    logic signed [DATA_WIDTH-1:0] r_gain_lat;
    logic        [DATA_WIDTH-1:0] r_gain [0:1];
    logic        [DATA_WIDTH-1:0] r_l_out_din;
    logic        [DATA_WIDTH-1:0] r_r_out_din;

    logic [1:0] w_eligible;
    logic       w_grant_valid;
    logic       w_grant_ch;
    logic       w_cur_full;
    logic       w_l_rd_en, w_r_rd_en, w_l_wr_en, w_r_wr_en;

    logic signed [2*DATA_WIDTH-1:0] w_a, w_b, w_prod;
    logic        [DATA_WIDTH-1:0]   w_res;
    logic                           w_unused_prod;

    assign w_eligible = {~bus.r_in_empty, ~bus.l_in_empty};

    gain_sched_rr u_rr (
        .eligible    (w_eligible),
        .last_ch     (r_last_ch),
        .grant_valid (w_grant_valid),
        .grant_ch    (w_grant_ch)
    );

    assign w_cur_full = (r_cur_ch == CH_R) ? bus.r_out_full : bus.l_out_full;

    always_comb begin
        w_state_nxt = r_state;
        w_l_rd_en   = 1'b0;
        w_r_rd_en   = 1'b0;
        w_l_wr_en   = 1'b0;
        w_r_wr_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = MUL;
                    w_l_rd_en   = (w_grant_ch == CH_L);
                    w_r_rd_en   = (w_grant_ch == CH_R);
                end
            end
            MUL:   w_state_nxt = WRITE;
            WRITE: begin
                if (!w_cur_full) begin
                    w_state_nxt = IDLE;
                    w_l_wr_en   = (r_cur_ch == CH_L);
                    w_r_wr_en   = (r_cur_ch == CH_R);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sign-extend both operands so the low 2*DATA_WIDTH bits are the exact signed product.
    assign w_a           = {{DATA_WIDTH{r_sample[DATA_WIDTH-1]}}, r_sample};
    assign w_b           = {{DATA_WIDTH{r_gain_lat[DATA_WIDTH-1]}}, r_gain_lat};
    assign w_prod        = w_a * w_b;
    assign w_unused_prod = ^w_prod;

`ifdef GAIN_SCHED_SAT_EN
    logic signed [2*DATA_WIDTH-1:0] w_shift;
    logic        [DATA_WIDTH:0]     w_hi;
    assign w_shift = w_prod >>> FRAC_BITS;
    assign w_hi    = w_shift[2*DATA_WIDTH-1:DATA_WIDTH-1];
    always_comb begin
        w_res = w_shift[DATA_WIDTH-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_res = w_shift[2*DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_res = w_prod[FRAC_BITS +: DATA_WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last_ch   <= CH_R;
            r_cur_ch    <= CH_L;
            r_sample    <= '0;
            r_gain_lat  <= '0;
            r_l_out_din <= '0;
            r_r_out_din <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_grant_valid) begin
                r_sample   <= (w_grant_ch == CH_R) ? bus.r_in_dout : bus.l_in_dout;
                r_gain_lat <= r_gain[w_grant_ch];
                r_cur_ch   <= w_grant_ch;
                r_last_ch  <= w_grant_ch;
            end
            if (r_state == MUL) begin
                r_l_out_din <= (r_cur_ch == CH_L) ? w_res : '0;
                r_r_out_din <= (r_cur_ch == CH_R) ? w_res : '0;
            end
            if (r_state == WRITE && !w_cur_full) begin
                r_l_out_din <= '0;
                r_r_out_din <= '0;
            end
        end
    end

    // A grant in the same cycle as a cfg write reads the pre-write gain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gain[0] <= c_gain_one;
            r_gain[1] <= c_gain_one;
        end else if (bus.cfg_wr_en) begin
            r_gain[bus.cfg_ch] <= bus.cfg_gain;
        end
    end

    assign bus.l_in_rd_en  = w_l_rd_en;
    assign bus.r_in_rd_en  = w_r_rd_en;
    assign bus.l_out_wr_en = w_l_wr_en;
    assign bus.r_out_wr_en = w_r_wr_en;
    assign bus.l_out_din   = r_l_out_din;
    assign bus.r_out_din   = r_r_out_din;
    assign bus.busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_gain_sched.sv
// ============================================================================
// Module : tb_gain_sched
// Brief  : Directed bench with a transaction-level model of gain_sched.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gain_sched;
    import gain_sched_pkg::*;

    logic clk;
    logic rst_n;

    gain_sched_if #(.DATA_WIDTH(32)) bus ();

    gain_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [31:0] l_q[$];
    logic [31:0] r_q[$];

    logic        log_ch[$];
    logic [31:0] log_val[$];
    int          wr_cyc[$];
    int          pop_cyc[$];

    // Model: one optional in-flight transaction and its age since the pop.
    bit          m_has;
    int          m_age;
    bit          m_ch;
    logic [31:0] m_res;
    bit          m_last;
    logic [31:0] m_gain[2];

    bit e_rd_l, e_rd_r, e_wr_l, e_wr_r, e_grant, e_gch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] scale(input logic [31:0] s, input logic [31:0] g);
        longint p;
        p = longint'($signed(s)) * longint'($signed(g));
        p = p >>> 10;
`ifdef GAIN_SCHED_SAT_EN
        if (p > 64'sd2147483647)  return 32'h7fff_ffff;
        if (p < -64'sd2147483648) return 32'h8000_0000;
`endif
        return p[31:0];
    endfunction

    task automatic model_reset();
        m_has     = 0;
        m_age     = 0;
        m_ch      = 0;
        m_res     = '0;
        m_last    = 1;
        m_gain[0] = 32'd1024;
        m_gain[1] = 32'd1024;
    endtask

    task automatic drive_fifo();
        bus.l_in_dout  = (l_q.size() > 0) ? l_q[0] : '0;
        bus.r_in_dout  = (r_q.size() > 0) ? r_q[0] : '0;
        bus.l_in_empty = (l_q.size() == 0);
        bus.r_in_empty = (r_q.size() == 0);
    endtask

    // One clock: compare at negedge, then apply the posedge effects to model and FIFOs.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e_grant = !m_has && (l_q.size() > 0 || r_q.size() > 0);
            if (l_q.size() > 0 && r_q.size() > 0) e_gch = ~m_last;
            else                                  e_gch = (l_q.size() == 0);
            e_rd_l = e_grant && !e_gch;
            e_rd_r = e_grant && e_gch;
            e_wr_l = m_has && m_age >= 1 && !m_ch && !bus.l_out_full;
            e_wr_r = m_has && m_age >= 1 &&  m_ch && !bus.r_out_full;
            chk("l_in_rd_en", bus.l_in_rd_en, e_rd_l);
            chk("r_in_rd_en", bus.r_in_rd_en, e_rd_r);
            chk("l_out_wr_en", bus.l_out_wr_en, e_wr_l);
            chk("r_out_wr_en", bus.r_out_wr_en, e_wr_r);
            chk("busy", bus.busy, m_has);
            if (m_has && m_age >= 1) begin
                chk("cur_out_din", m_ch ? bus.r_out_din : bus.l_out_din, m_res);
                chk("other_out_din", m_ch ? bus.l_out_din : bus.r_out_din, 32'd0);
            end
            if (bus.l_out_wr_en) begin log_ch.push_back(0); log_val.push_back(bus.l_out_din); wr_cyc.push_back(cyc); end
            if (bus.r_out_wr_en) begin log_ch.push_back(1); log_val.push_back(bus.r_out_din); wr_cyc.push_back(cyc); end
            if (bus.l_in_rd_en || bus.r_in_rd_en) pop_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                model_reset();
            end else begin
                if (e_grant) begin
                    m_has  = 1;
                    m_age  = 0;
                    m_ch   = e_gch;
                    m_last = e_gch;
                    if (e_gch) m_res = scale(r_q.pop_front(), m_gain[1]);
                    else       m_res = scale(l_q.pop_front(), m_gain[0]);
                end else if (m_has) begin
                    if (m_age == 0)          m_age = 1;
                    else if (e_wr_l || e_wr_r) m_has = 0;
                end
                if (bus.cfg_wr_en) m_gain[bus.cfg_ch] = bus.cfg_gain;
            end
            drive_fifo();
        end
    endtask

    task automatic cfg(input logic ch, input logic [31:0] g);
        bus.cfg_wr_en = 1'b1;
        bus.cfg_ch    = ch;
        bus.cfg_gain  = g;
        step(1);
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic wait_log(input int n, input string name);
        int budget = 60;
        while (log_val.size() < n && budget > 0) begin
            step(1);
            budget--;
        end
        n_checks++;
        if (log_val.size() < n) begin
            n_err++;
            $display("FAIL %s timeout: got %0d writes expected %0d", name, log_val.size(), n);
        end
    endtask

    task automatic chk_log(input int idx, input logic ch, input logic [31:0] val, input string name);
        if (idx < log_val.size()) begin
            chk({name, "_ch"}, log_ch[idx], ch);
            chk({name, "_val"}, log_val[idx], val);
        end else begin
            chk({name, "_missing"}, 32'(log_val.size()), 32'(idx + 1));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step(2);
        rst_n = 1'b1;
    endtask

    int base;
    int pbase;

    initial begin
        rst_n          = 1'b0;
        bus.cfg_wr_en  = 1'b0;
        bus.cfg_ch     = 1'b0;
        bus.cfg_gain   = '0;
        bus.l_out_full = 1'b0;
        bus.r_out_full = 1'b0;
        model_reset();
        drive_fifo();
        #2;
        chk("rst_l_rd_en", bus.l_in_rd_en, 32'd0);
        chk("rst_r_rd_en", bus.r_in_rd_en, 32'd0);
        chk("rst_l_wr_en", bus.l_out_wr_en, 32'd0);
        chk("rst_r_wr_en", bus.r_out_wr_en, 32'd0);
        chk("rst_l_out_din", bus.l_out_din, 32'd0);
        chk("rst_r_out_din", bus.r_out_din, 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Passthrough at gain 1.0, write two cycles after the pop cycle
        base = log_val.size(); pbase = pop_cyc.size();
        l_q.push_back(32'd1000); drive_fifo();
        wait_log(base + 1, "pass");
        chk_log(base, 0, 32'd1000, "pass");
        if (log_val.size() > base && pop_cyc.size() > pbase)
            chk("pass_latency", 32'(wr_cyc[base] - pop_cyc[pbase]), 32'd2);

        // Programmed gains
        cfg(1'b1, 32'd2048);
        base = log_val.size();
        r_q.push_back(-32'sd300); drive_fifo();
        wait_log(base + 1, "gain_r");
        chk_log(base, 1, -32'sd600, "gain_r");
        cfg(1'b0, 32'd512);
        l_q.push_back(32'd7); drive_fifo();
        wait_log(base + 2, "gain_l");
        chk_log(base + 1, 0, 32'd3, "gain_l");

        // Alternation from a fresh reset: left wins the first tie
        do_reset();
        base = log_val.size(); pbase = pop_cyc.size();
        l_q.push_back(32'd1); l_q.push_back(32'd2); l_q.push_back(32'd3);
        r_q.push_back(32'd10); r_q.push_back(32'd20); r_q.push_back(32'd30);
        drive_fifo();
        wait_log(base + 6, "alt");
        chk_log(base + 0, 0, 32'd1,  "alt0");
        chk_log(base + 1, 1, 32'd10, "alt1");
        chk_log(base + 2, 0, 32'd2,  "alt2");
        chk_log(base + 3, 1, 32'd20, "alt3");
        chk_log(base + 4, 0, 32'd3,  "alt4");
        chk_log(base + 5, 1, 32'd30, "alt5");
        for (int i = 1; i < 6; i++)
            if (pop_cyc.size() > pbase + i)
                chk("alt_pop_spacing", 32'(pop_cyc[pbase+i] - pop_cyc[pbase+i-1]), 32'd3);

        // Backpressure on left blocks the pending right sample too
        base = log_val.size();
        bus.l_out_full = 1'b1;
        l_q.push_back(32'd42); r_q.push_back(32'd9); drive_fifo();
        step(3);
        step(5);
        chk("bp_no_write", 32'(log_val.size()), 32'(base));
        chk("bp_r_not_popped", 32'(r_q.size()), 32'd1);
        bus.l_out_full = 1'b0;
        step(1);
        chk("bp_write_on_release", 32'(log_val.size()), 32'(base + 1));
        chk_log(base, 0, 32'd42, "bp_l");
        wait_log(base + 2, "bp_r");
        chk_log(base + 1, 1, 32'd9, "bp_r");

        // Gain write during MUL of an in-flight left sample
        step(2);
        base = log_val.size();
        l_q.push_back(32'd5); drive_fifo();
        step(1);
        cfg(1'b0, 32'd4096);
        wait_log(base + 1, "race_old");
        chk_log(base, 0, 32'd5, "race_old");
        l_q.push_back(32'd5); drive_fifo();
        wait_log(base + 2, "race_new");
        chk_log(base + 1, 0, 32'd20, "race_new");

        // Overflow at gain 4.0
        l_q.push_back(32'h4000_0000); drive_fifo();
        wait_log(base + 3, "ovf");
`ifdef GAIN_SCHED_SAT_EN
        chk_log(base + 2, 0, 32'h7fff_ffff, "ovf");
`else
        chk_log(base + 2, 0, 32'h0000_0000, "ovf");
`endif

        // Reset while a sample is in MUL: it is dropped and gains return to 1.0
        step(2);
        base = log_val.size();
        l_q.push_back(32'd5); drive_fifo();
        step(1);
        chk("mid_busy_before", bus.busy, 32'd1);
        do_reset();
        chk("mid_busy_after", bus.busy, 32'd0);
        step(4);
        chk("mid_no_write", 32'(log_val.size()), 32'(base));
        l_q.push_back(32'd3); drive_fifo();
        wait_log(base + 1, "mid_gain");
        chk_log(base, 0, 32'd3, "mid_gain");
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
